// File: rtl/snn_input_loader.sv
// snn_input_loader: collects a 1-bit-per-pixel image from a byte stream,
// unpacks it LSB-first into a pixel memory, starts snn_core and serves its
// pixel reads. New frames are refused until snn_core reports completion.
module snn_input_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    input  logic [ADDR_W-1:0] addr_input_unit,
    input  logic              core_done,
    output logic              q_input,
    output logic              start,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_UNPACK,
        S_START,
        S_WAIT_CORE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        bit_cnt;
    logic [7:0]        sh;
    logic [7:0]        hold_data;
    logic              hold_full;
    logic              mem [NUM_PIXELS];

    logic in_load;
    logic in_unpack;
    logic last_bit;
    logic frame_end;
    logic drain;
    logic capture;
    logic drop;

    assign in_load   = (state == S_LOAD);
    assign in_unpack = (state == S_UNPACK);
    // Eighth write of the current byte happens this cycle.
    assign last_bit  = in_unpack && (bit_cnt == 3'd7);
    assign frame_end = last_bit && (wr_addr == LAST_ADDR);
    // The hold buffer empties into the shift register either from idle LOAD
    // or straight after the previous byte finishes (no bubble between bytes).
    assign drain     = hold_full && (in_load || (last_bit && !frame_end));
    // A byte arriving in the same cycle the buffer drains still fits.
    assign capture   = rx_rdy && (in_load || in_unpack) && (!hold_full || drain);
    assign drop      = rx_rdy && !capture;

    // Control: FSM, write address, bit counter, buffer flag and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            wr_addr   <= '0;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
            start     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            start <= 1'b0;

            if (drop) begin
                overrun <= 1'b1;
            end

            if (capture) begin
                hold_full <= 1'b1;
            end else if (drain) begin
                hold_full <= 1'b0;
            end

            case (state)
                S_LOAD: begin
                    if (hold_full) begin
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    wr_addr <= frame_end ? '0 : wr_addr + ADDR_W'(1);
                    if (last_bit) begin
                        if (frame_end) begin
                            start <= 1'b1;
                            state <= S_START;
                        end else if (!hold_full) begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT_CORE;
                end
                S_WAIT_CORE: begin
                    if (core_done) begin
                        busy  <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    // Data path: hold register capture and LSB-first shift register.
    always_ff @(posedge clk) begin
        if (capture) begin
            hold_data <= rx_data;
        end
        if (drain) begin
            sh <= hold_data;
        end else if (in_unpack) begin
            sh <= {1'b0, sh[7:1]};
        end
    end

    // Pixel memory write; suppressed while reset is held so contents survive.
    always_ff @(posedge clk) begin
        if (rst_n && in_unpack) begin
            mem[wr_addr] <= sh[0];
        end
    end

    // Registered read port; out-of-range addresses read as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_input <= 1'b0;
        end else if (addr_input_unit <= LAST_ADDR) begin
            q_input <= mem[addr_input_unit];
        end else begin
            q_input <= 1'b0;
        end
    end

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed/random bench for snn_input_loader with a byte-list image model.
module tb_snn_input_loader;

    localparam int NPIX = 784;
    localparam int NBYTES = NPIX / 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic [9:0] addr_input_unit;
    logic       core_done;
    logic       q_input;
    logic       start;
    logic       busy;
    logic       overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_at = 0;
    int rx_cyc = 0;
    logic model_img [NPIX];

    snn_input_loader #(.NUM_PIXELS(NPIX), .ADDR_W(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_rdy(rx_rdy),
        .addr_input_unit(addr_input_unit),
        .core_done(core_done),
        .q_input(q_input),
        .start(start),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs are observed 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (start === 1'b1) begin
            start_cnt++;
            start_at = cyc;
        end
    endtask

    // Pixel k*8+i of the image is bit i of the k-th accepted byte.
    task automatic model_byte(input int k, input logic [7:0] b);
        for (int i = 0; i < 8; i++) model_img[8 * k + i] = b[i];
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_rdy = 1'b1;
        cycle();
        rx_cyc = cyc;
        rx_rdy = 1'b0;
        for (int i = 1; i < gap; i++) cycle();
    endtask

    task automatic read_px(input int a, output logic q);
        addr_input_unit = 10'(a);
        cycle();
        q = q_input;
    endtask

    task automatic check_image(input string tag);
        int mism;
        logic q;
        mism = 0;
        for (int p = 0; p < NPIX; p++) begin
            read_px(p, q);
            if (q !== model_img[p]) mism++;
        end
        chk(tag, mism, 0);
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        cycle();
        core_done = 1'b0;
        cycle();
    endtask

    initial begin
        int s0;
        int lat;
        logic q;
        logic [7:0] b;

        rst_n = 1'b0;
        rx_data = 8'h00;
        rx_rdy = 1'b0;
        addr_input_unit = '0;
        core_done = 1'b0;

        // Reset state
        cycle();
        cycle();
        chk("rst_start", start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_q", q_input, 1'b0);
        rst_n = 1'b1;
        cycle();

        // Frame 1: 0xA5 bytes spaced 20 clk
        s0 = start_cnt;
        for (int k = 0; k < NBYTES; k++) begin
            model_byte(k, 8'hA5);
            send_byte(8'hA5, 20);
        end
        lat = start_at - rx_cyc;
        chk("f1_start_once", start_cnt - s0, 1);
        chk("f1_latency_ok", (lat > 0 && lat <= 10), 1'b1);
        chk("f1_busy", busy, 1'b1);
        chk("f1_overrun", overrun, 1'b0);
        for (int p = 0; p < 8; p++) begin
            read_px(p, q);
            chk($sformatf("f1_px%0d", p), q, model_img[p]);
        end
        check_image("f1_image");

        // Release core, then frame 2: back-to-back bytes via the hold buffer
        pulse_done();
        chk("f1_done_busy", busy, 1'b0);
        s0 = start_cnt;
        model_byte(0, 8'hFF);
        send_byte(8'hFF, 1);
        model_byte(1, 8'h00);
        send_byte(8'h00, 9);
        for (int k = 2; k < NBYTES; k++) begin
            b = 8'($urandom);
            model_byte(k, b);
            send_byte(b, 9);
        end
        repeat (12) cycle();
        chk("f2_start_once", start_cnt - s0, 1);
        chk("f2_overrun", overrun, 1'b0);
        read_px(3, q);
        chk("f2_px3", q, 1'b1);
        read_px(12, q);
        chk("f2_px12", q, 1'b0);
        check_image("f2_image");

        // Bytes during WAIT_CORE are dropped and leave the image untouched
        s0 = start_cnt;
        for (int k = 0; k < 5; k++) send_byte(8'($urandom), 2);
        repeat (12) cycle();
        chk("wait_overrun", overrun, 1'b1);
        chk("wait_no_start", start_cnt - s0, 0);
        chk("wait_busy", busy, 1'b1);
        check_image("wait_image");
        pulse_done();
        chk("wait_done_busy", busy, 1'b0);

        // Partial frame abandoned by reset after byte 50
        for (int k = 0; k < 50; k++) send_byte(8'($urandom), 9);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("mrst_start", start, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_overrun", overrun, 1'b0);

        // Fresh frame of 0x01 bytes
        s0 = start_cnt;
        for (int k = 0; k < NBYTES; k++) begin
            model_byte(k, 8'h01);
            send_byte(8'h01, 9);
        end
        repeat (12) cycle();
        lat = start_at - rx_cyc;
        chk("f3_start_once", start_cnt - s0, 1);
        chk("f3_latency_ok", (lat > 0 && lat <= 10), 1'b1);
        read_px(8, q);
        chk("f3_px8", q, 1'b1);
        read_px(9, q);
        chk("f3_px9", q, 1'b0);
        check_image("f3_image");
        pulse_done();

        // Three consecutive pulses: third falls on a full buffer and is lost
        s0 = start_cnt;
        b = 8'($urandom);
        model_byte(0, b);
        send_byte(b, 1);
        b = 8'($urandom);
        model_byte(1, b);
        send_byte(b, 1);
        send_byte(8'($urandom), 9);
        chk("trip_overrun", overrun, 1'b1);
        for (int k = 2; k < NBYTES - 1; k++) begin
            b = 8'($urandom);
            model_byte(k, b);
            send_byte(b, 9);
        end
        repeat (12) cycle();
        chk("trip_97_no_start", start_cnt - s0, 0);
        b = 8'($urandom);
        model_byte(NBYTES - 1, b);
        send_byte(b, 9);
        repeat (12) cycle();
        chk("trip_98_start", start_cnt - s0, 1);
        chk("trip_overrun_sticky", overrun, 1'b1);
        check_image("trip_image");
        pulse_done();

        // All-ones frame and read-address boundaries
        s0 = start_cnt;
        for (int k = 0; k < NBYTES; k++) begin
            model_byte(k, 8'hFF);
            send_byte(8'hFF, 9);
        end
        repeat (12) cycle();
        chk("f5_start_once", start_cnt - s0, 1);
        read_px(783, q);
        chk("rd_783", q, 1'b1);
        read_px(784, q);
        chk("rd_784", q, 1'b0);
        read_px(783, q);
        chk("rd_783_again", q, 1'b1);
        read_px(1023, q);
        chk("rd_1023", q, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snn_input_loader.md
Name: snn_input_loader

Overview:
- Upstream stage of snn_core. Accepts a 784-pixel, 1-bit-per-pixel image as a stream of 98 bytes from the UART receiver.
- Unpacks each byte into an internal 784x1 input-unit memory, then pulses start to snn_core.
- Serves snn_core's pixel reads through the addr_input_unit / q_input pair.
- Holds off new frames until snn_core reports done.

Parameters:
NUM_PIXELS, 784, pixels per image; memory depth; must be a multiple of 8
ADDR_W, 10, width of pixel address; ceil(log2(NUM_PIXELS))

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
rx_data  input  8  received byte from UART receiver
rx_rdy  input  1  one-cycle pulse; rx_data valid this cycle
addr_input_unit  input  ADDR_W  pixel read address driven by snn_core
core_done  input  1  one-cycle pulse from snn_core at end of classification
q_input  output  1  pixel value at addr_input_unit, registered
start  output  1  one-cycle pulse to snn_core; image fully loaded
busy  output  1  high from first accepted byte of a frame until core_done
overrun  output  1  sticky; a byte was dropped

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=LOAD; wr_addr=0; hold buffer empty.
  - start=0, busy=0, overrun=0, q_input=0.
  - Memory contents are not cleared.
  - Reset mid-frame abandons the partial frame; the next byte accepted is byte 0.
- Bit mapping: byte k (0..97), bit i (LSB first) -> pixel 8k+i.
- Hold buffer: one-entry register plus a full flag, sitting between rx and the unpacker.
  - rx_rdy with buffer empty, in state LOAD or UNPACK -> byte captured, full=1.
  - rx_rdy with buffer full -> byte dropped, overrun=1.
  - rx_rdy in state START or WAIT_CORE -> byte dropped, overrun=1.
  - Simultaneous rx_rdy and buffer drain in the same cycle -> new byte captured, no overrun.
- States:
  - LOAD: if buffer full, move the buffer into shift register sh[7:0], clear full, set bit counter=0, busy=1, go to UNPACK. Otherwise stay.
  - UNPACK: each cycle write mem[wr_addr]<=sh[0], shift sh right by 1, wr_addr+1, bit counter+1. After 8 writes (8 cycles):
    - if the last write was to address NUM_PIXELS-1 -> go to START, wr_addr=0;
    - else if buffer full -> reload sh and stay in UNPACK with no idle cycle;
    - else -> go to LOAD.
  - START: start=1 for exactly this cycle; go to WAIT_CORE. start is never high outside START.
  - WAIT_CORE: wait for core_done. On core_done -> busy=0, go to LOAD. core_done in any other state is ignored.
- Throughput: 8 clk per byte plus at most 1 cycle from capture to unpack start.
- Latency: last byte's rx_rdy to start pulse ≤ 10 clk.
- Read port:
  - q_input <= mem[addr_input_unit] at each edge, so data appears 1 cycle after the address.
  - Reads are permitted in every state.
  - addr_input_unit ≥ NUM_PIXELS -> q_input=0.
  - Read and write to the same address in the same cycle -> q_input returns old data.
- overrun clears only on reset. Dropped bytes do not advance wr_addr.
- wr_addr never exceeds NUM_PIXELS-1 (wraps to 0 at frame end).

Test Plan:
- Reset, then 98 bytes 0xA5 spaced 20 clk apart -> start pulses once, ≤10 clk after the 98th rx_rdy. Reading addr 0..7 gives 1,0,1,0,0,1,0,1; busy=1; overrun=0.
- Back-to-back bytes 0xFF,0x00 with rx_rdy on consecutive cycles, then 96 more bytes at 9-clk spacing -> both first bytes retained (buffer). Pixels 0-7=1, 8-15=0, overrun=0.
- Three rx_rdy pulses on consecutive cycles while UNPACK is busy -> third byte dropped, overrun=1 and stays 1; the frame still needs 98 accepted bytes before start.
- After start and before core_done, send 5 bytes -> all dropped, overrun=1. Pulse core_done -> busy=0; the next 98 bytes load a new frame and a second start occurs.
- Assert rst_n low for 1 cycle after byte 50 -> start=0, busy=0. Then 98 fresh bytes 0x01 -> pixel 8k=1, others 0, start pulses once.
- Read addr 783 with all-ones image -> q_input=1 one cycle later. Read addr 784 or 1023 -> q_input=0.
